// File: rtl/chocolate_pkg.sv
// Shared constants for the memory bus arbiter slice.
// State encoding, bus direction and grant identifiers.
package chocolate_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   localparam logic GRANT_IF = 1'b0;
   localparam logic GRANT_D  = 1'b1;

endpackage

// File: rtl/rr_picker2.sv
// Two-way round-robin chooser.
// On contention the port that did not win last time is picked.
module rr_picker2
   import chocolate_pkg::*;
(
   input  logic req_a,
   input  logic req_b,
   input  logic last,
   output logic grant_valid,
   output logic grant_sel
);

   // Pick a winner; ties go to the port not granted last.
   always_comb begin
      grant_valid = req_a | req_b;
      grant_sel   = GRANT_IF;
      unique case (1'b1)
         (req_a & req_b):
            grant_sel = (last == GRANT_D) ? GRANT_IF : GRANT_D;
         (req_b & ~req_a):
            grant_sel = GRANT_D;
         default:
            grant_sel = GRANT_IF;
      endcase
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the external byte bus between fetch and data ports.
// Sequence per access: grant, address/wait phase, done/turnaround.
module mem_bus_arbiter
   import chocolate_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF
) (
   input  logic              dbg_clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rw_mem,
   output logic              busy
);

   logic [1:0] state;
   logic [3:0] cnt;
   logic       sel;
   logic       last_grant;
   logic       grant_valid;
   logic       grant_sel;

   rr_picker2 u_pick (
      .req_a       (if_req),
      .req_b       (d_req),
      .last        (last_grant),
      .grant_valid (grant_valid),
      .grant_sel   (grant_sel)
   );

   // Busy whenever a transaction is in flight.
   always_comb begin
      busy = (state != ST_IDLE);
   end

   // Arbitration FSM; bus outputs are latched at grant and held.
   always_ff @(posedge dbg_clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         sel        <= GRANT_IF;
         last_grant <= GRANT_D;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         rw_mem     <= RW_READ;
         if_ack     <= 1'b0;
         d_ack      <= 1'b0;
         if_rdata   <= '0;
         d_rdata    <= '0;
      end else begin
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  sel        <= grant_sel;
                  last_grant <= grant_sel;
                  cnt        <= 4'(WAIT_CYCLES);
                  state      <= ST_ACCESS;
                  if (grant_sel == GRANT_D) begin
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                     rw_mem    <= d_we ? RW_WRITE : RW_READ;
                  end else begin
                     mem_addr <= if_addr;
                     rw_mem   <= RW_READ;
                  end
               end
            end
            ST_ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  if (rw_mem == RW_READ) begin
                     if (sel == GRANT_D) d_rdata  <= mem_rdata;
                     else                if_rdata <= mem_rdata;
                  end
                  if (sel == GRANT_D) d_ack  <= 1'b1;
                  else                if_ack <= 1'b1;
                  rw_mem <= RW_READ;
                  state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state  <= ST_IDLE;
               rw_mem <= RW_READ;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single 8-bit external memory bus (mem_io/rw_mem) between the instruction-fetch port (pc_instr) and the data port (load-next immediate, load/store). It sequences each access as grant -> address/wait phase -> completion, and drives rw_mem, the address and the write data. It guarantees a turnaround cycle before the bus changes direction. The top-level tristate assignment stays in processor and is fed from this block's rw_mem and mem_wdata.

Parameters:
WAIT_CYCLES, 1, extra cycles the address is held before read data is sampled (legal range 0-15)
ADDR_W, 8, memory address width
DATA_W, 8, memory data width

Ports:
dbg_clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched byte, valid while if_ack=1, holds afterwards
if_ack  out  1  one-cycle completion pulse, fetch port
d_req  in  1  data request, held until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load result, valid while d_ack=1, holds afterwards
d_ack  out  1  one-cycle completion pulse, data port
mem_addr  out  ADDR_W  address to memory
mem_wdata  out  DATA_W  byte driven onto mem_io when rw_mem=1
mem_rdata  in  DATA_W  byte read from mem_io
rw_mem  out  1  1=write (block drives bus), 0=read/idle (bus released)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (sync, rst=1 at a clock edge): state=IDLE; mem_addr=0, mem_wdata=0, rw_mem=0, if_ack=d_ack=0, if_rdata=d_rdata=0, busy=0, last_grant=DATA.
- FSM states:
  - IDLE: if any req is high, grant and latch addr/we/wdata, load cnt=WAIT_CYCLES, go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: mem_addr=latched addr; rw_mem=latched we (fetch always 0); mem_wdata=latched wdata. If cnt!=0, decrement cnt. If cnt==0, capture mem_rdata into the granted port's rdata register (reads only) and go to DONE.
  - DONE: rw_mem=0 (bus turnaround); pulse the granted port's ack for exactly this cycle; go to IDLE. No grant is made in DONE.
- Latency: request first seen in IDLE at cycle t -> ACCESS occupies t+1 .. t+1+WAIT_CYCLES -> ack at t+2+WAIT_CYCLES. Throughput is one access per WAIT_CYCLES+3 cycles.
- Arbitration in IDLE:
  - Only one req high: that port is granted.
  - Both high: the port not in last_grant is granted (round-robin). last_grant updates on every grant.
- rw_mem is high only during ACCESS of a store. It is 0 in IDLE, DONE and during reset.
- Requests:
  - Inputs are sampled only at grant; later changes to addr/wdata/we are ignored.
  - Dropping req before ack: the access still completes and the ack still pulses.
  - A req still high in the IDLE cycle after its ack counts as a new request.
- rdata registers update only on a read completion for their own port; otherwise they hold.
- Reset mid-access: the transaction is abandoned with no ack, and the reset values apply on the next cycle.
- WAIT_CYCLES=0: ACCESS lasts exactly one cycle.

Decomposition:
- Shared package (chocolate_pkg): state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), RW_READ=1'b0/RW_WRITE=1'b1, GRANT_IF=1'b0/GRANT_D=1'b1, ADDR_W/DATA_W defaults.
- One sub-module is natural: rr_picker2. It is a combinational 2-way round-robin chooser with inputs (req_a, req_b, last) and outputs (grant_valid, grant_sel).
- Counter and FSM stay in mem_bus_arbiter.

Test Plan:
- Reset then idle, rst=1 for 2 cycles then released, no reqs -> all outputs 0, busy=0, rw_mem=0 for 10 cycles.
- Single fetch, WAIT_CYCLES=1, if_req at t with if_addr=8'h10, memory model returns 8'hA5 -> mem_addr=8'h10 at t+1 and t+2, rw_mem=0, if_ack=1 only at t+3 with if_rdata=8'hA5, d_ack never asserted.
- Store: d_req, d_we=1, d_addr=8'h20, d_wdata=8'h3C -> rw_mem=1 and mem_wdata=8'h3C exactly during ACCESS cycles; rw_mem=0 in DONE; d_ack pulses once; memory[8'h20]=8'h3C.
- Contention: if_req and d_req both held high from t -> grant order after reset is fetch, data, fetch, data. Acks alternate every WAIT_CYCLES+3 cycles; no ack is ever on both ports in the same cycle.
- Mid-access reset: rst=1 in the second ACCESS cycle of a store -> no d_ack, rw_mem=0 next cycle, busy=0; a subsequent fetch completes normally.
- WAIT_CYCLES=0, load from 8'hFF returning 8'h01 -> d_ack at t+2 with d_rdata=8'h01; d_rdata still holds 8'h01 after a following fetch completes.
